wb_master_arbiter: RTL and testbench
====================================

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 64, slave-ack watchdog limit in clk cycles (range 2-255).
REQ-002 Port: clk  in  1  system clock (27 MHz domain).
REQ-003 Port: rst_n  in  1  reset; asynchronous assert, active-low.
REQ-004 Ports: m0_wb_adr_i, m0_wb_dat_i  in  8 each; m0_wb_cyc_i, m0_wb_stb_i, m0_wb_we_i  in  1 each; master 0 (SPI bridge) request.
REQ-005 Ports: m0_wb_dat_o  out  8, m0_wb_ack_o  out  1; master 0 response.
REQ-006 Ports: m1_wb_adr_i, m1_wb_dat_i  in  8 each; m1_wb_cyc_i, m1_wb_stb_i, m1_wb_we_i  in  1 each; master 1 (USB serial bridge) request.
REQ-007 Ports: m1_wb_dat_o  out  8, m1_wb_ack_o  out  1; master 1 response.
REQ-008 Ports: s_wb_adr_o, s_wb_dat_o  out  8 each; s_wb_cyc_o, s_wb_stb_o, s_wb_we_o  out  1 each; shared bus toward the address decoder.
REQ-009 Ports: s_wb_dat_i  in  8, s_wb_ack_i  in  1; shared bus response from the decoder.
REQ-010 Ports: timeout_flag  out  1, sticky watchdog event; timeout_clr  in  1, synchronous clear of timeout_flag.
REQ-011 Port: grant  out  2  one-hot current owner (bit0 = m0, bit1 = m1; 00 = idle).

Function
REQ-012 FSM states: IDLE, OWN0, OWN1; state, owner, last-served pointer, and watchdog counter are registers.
REQ-013 IDLE: a master's cyc high requests; a single requester is granted at the next edge (IDLE->OWN0/OWN1).
REQ-014 Both requesting in IDLE: grant goes to the master not served last (round-robin); after reset, m0 has priority.
REQ-015 While OWNx: s_wb_adr_o/dat_o/we_o/cyc_o/stb_o = owner's inputs combinationally; s_wb_* = 0 in IDLE.
REQ-016 Ack and read data route only to the owner: mx_wb_ack_o = s_wb_ack_i when owner = x, else 0; mx_wb_dat_o = s_wb_dat_i when owner = x, else 0x00.
REQ-017 Grant is held across multiple stb/ack transfers while the owner's cyc remains high (no preemption).
REQ-018 Owner drops cyc: return to IDLE at next edge, update last-served pointer; at least one IDLE cycle between grants.
REQ-019 Non-owner requests are neither acked nor lost; they are served on the next arbitration.
REQ-020 Watchdog: counter clears when owner stb is low or s_wb_ack_i is high; increments each cycle owner stb is high and s_wb_ack_i is low.
REQ-021 Counter reaching TIMEOUT-1 with no ack: for one cycle, owner ack = 1, owner dat = 0xFF, s_wb_cyc_o/stb_o forced 0; timeout_flag sets; counter clears.
REQ-022 s_wb_ack_i arriving in the same cycle as watchdog expiry: the slave ack wins, no timeout, flag unchanged.
REQ-023 timeout_clr and a new timeout event in the same cycle: the flag stays set (set wins).
REQ-024 Counter width 8 bits, saturating; no wrap-around.

Reset
REQ-025 rst_n low: asynchronous force to IDLE; grant = 00, all ack outputs 0, all s_wb_* outputs 0, dat outputs 0x00, timeout_flag 0, counter 0, last-served = m1.
REQ-026 Reset asserted mid-transfer: the transfer is abandoned and no ack is issued; after release, arbitration restarts from IDLE.

Verification
REQ-027 m0 alone: cyc/stb/we = 1, adr 0x05, dat 0xA5; slave acks after 2 cycles -> s_wb_adr_o = 0x05, m0 ack 1 cycle, m1 ack 0, grant = 01.
REQ-028 Both cyc rise in the same cycle after reset -> m0 granted first; m0 releases -> one IDLE cycle, then grant = 10.
REQ-029 Alternating continuous requests from both masters, 8 transactions -> grants strictly alternate 01/10.
REQ-030 m1 read, adr 0x12, slave never acks, TIMEOUT = 64 -> m1 ack at cycle 64 of stb with dat 0xFF; s_wb_stb_o 0 that cycle; timeout_flag 1 until timeout_clr pulse.
REQ-031 Slave ack in the exact expiry cycle -> m1 receives slave data (e.g. 0x3C), timeout_flag stays 0.
REQ-032 rst_n pulsed low during an OWN0 wait -> outputs return to reset values immediately, no ack; m1's pending request is granted after release.

Source files
------------

// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: two-master round-robin Wishbone arbiter with slave-ack watchdog
// Ports: clk/rst_n clock and async active-low reset; m0_wb_*/m1_wb_* master request
// inputs and routed responses; s_wb_* shared bus toward the decoder and its response;
// timeout_flag sticky watchdog event, timeout_clr its sync clear; grant one-hot owner.
module wb_master_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] m0_wb_adr_i,
  input  logic [7:0] m0_wb_dat_i,
  input  logic       m0_wb_cyc_i,
  input  logic       m0_wb_stb_i,
  input  logic       m0_wb_we_i,
  output logic [7:0] m0_wb_dat_o,
  output logic       m0_wb_ack_o,
  input  logic [7:0] m1_wb_adr_i,
  input  logic [7:0] m1_wb_dat_i,
  input  logic       m1_wb_cyc_i,
  input  logic       m1_wb_stb_i,
  input  logic       m1_wb_we_i,
  output logic [7:0] m1_wb_dat_o,
  output logic       m1_wb_ack_o,
  output logic [7:0] s_wb_adr_o,
  output logic [7:0] s_wb_dat_o,
  output logic       s_wb_cyc_o,
  output logic       s_wb_stb_o,
  output logic       s_wb_we_o,
  input  logic [7:0] s_wb_dat_i,
  input  logic       s_wb_ack_i,
  output logic       timeout_flag,
  input  logic       timeout_clr,
  output logic [1:0] grant
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state_q, state_d;
  logic last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic flag_q, flag_d;
  logic own0, own1, o_cyc, o_stb, expire, r_ack;
  logic [7:0] r_dat;
  assign own0 = state_q == OWN0;
  assign own1 = state_q == OWN1;
  assign grant = {own1, own0};
  assign o_cyc = own0 ? m0_wb_cyc_i : own1 ? m1_wb_cyc_i : 1'b0;
  assign o_stb = own0 ? m0_wb_stb_i : own1 ? m1_wb_stb_i : 1'b0;
  // a slave ack in the expiry cycle suppresses the timeout
  assign expire = o_stb & ~s_wb_ack_i & (cnt_q == 8'(TIMEOUT - 1));
  assign s_wb_adr_o = own0 ? m0_wb_adr_i : own1 ? m1_wb_adr_i : 8'h00;
  assign s_wb_dat_o = own0 ? m0_wb_dat_i : own1 ? m1_wb_dat_i : 8'h00;
  assign s_wb_we_o = own0 ? m0_wb_we_i : own1 ? m1_wb_we_i : 1'b0;
  assign s_wb_cyc_o = o_cyc & ~expire;
  assign s_wb_stb_o = o_stb & ~expire;
  assign r_ack = s_wb_ack_i | expire;
  assign r_dat = expire ? 8'hFF : s_wb_dat_i;
  assign m0_wb_ack_o = own0 & r_ack;
  assign m1_wb_ack_o = own1 & r_ack;
  assign m0_wb_dat_o = own0 ? r_dat : 8'h00;
  assign m1_wb_dat_o = own1 ? r_dat : 8'h00;
  assign timeout_flag = flag_q;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    // last_q = 1 means m1 was served last, so m0 wins a tie
    if (state_q == IDLE)
      state_d = (m0_wb_cyc_i & (~m1_wb_cyc_i | last_q)) ? OWN0 : m1_wb_cyc_i ? OWN1 : IDLE;
    else if (~o_cyc) begin
      state_d = IDLE;
      last_d = own1;
    end
    cnt_d = (~o_stb | s_wb_ack_i | expire) ? 8'h00 : (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'h01;
    flag_d = expire | (flag_q & ~timeout_clr);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      cnt_q <= 8'h00;
      flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      flag_q <= flag_d;
    end
  end
endmodule

// File: tb/tb_wb_master_arbiter.sv
// tb_wb_master_arbiter: directed self-checking bench for wb_master_arbiter
module tb_wb_master_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] m0_adr = '0, m0_dat = '0, m1_adr = '0, m1_dat = '0, s_dat = '0;
  logic m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic s_ack = 0, timeout_clr = 0;
  logic [7:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic m0_ack_o, m1_ack_o, s_cyc_o, s_stb_o, s_we_o, timeout_flag;
  logic [1:0] grant;
  int n_cmp = 0;
  int n_bad = 0;
  wb_master_arbiter #(.TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat), .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb),
    .m0_wb_we_i(m0_we), .m0_wb_dat_o(m0_dat_o), .m0_wb_ack_o(m0_ack_o),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat), .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb),
    .m1_wb_we_i(m1_we), .m1_wb_dat_o(m1_dat_o), .m1_wb_ack_o(m1_ack_o),
    .s_wb_adr_o(s_adr_o), .s_wb_dat_o(s_dat_o), .s_wb_cyc_o(s_cyc_o), .s_wb_stb_o(s_stb_o),
    .s_wb_we_o(s_we_o), .s_wb_dat_i(s_dat), .s_wb_ack_i(s_ack),
    .timeout_flag(timeout_flag), .timeout_clr(timeout_clr), .grant(grant)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_dut();
    rst_n = 0;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack, timeout_clr} = '0;
    repeat (2) tick();
    rst_n = 1;
    tick();
  endtask
  initial begin
    #2;
    check("rst_grant", grant, 0);
    check("rst_s_cyc", s_cyc_o, 0);
    check("rst_s_adr", s_adr_o, 0);
    check("rst_acks", {m0_ack_o, m1_ack_o}, 0);
    check("rst_dats", {m0_dat_o, m1_dat_o}, 0);
    check("rst_flag", timeout_flag, 0);
    reset_dut();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 8'h05; m0_dat = 8'hA5;
    #1;
    check("m0_pre_grant", grant, 0);
    check("m0_pre_s_cyc", s_cyc_o, 0);
    tick();
    check("m0_grant", grant, 2'b01);
    check("m0_s_adr", s_adr_o, 8'h05);
    check("m0_s_dat", s_dat_o, 8'hA5);
    check("m0_s_ctl", {s_cyc_o, s_stb_o, s_we_o}, 3'b111);
    check("m0_no_ack", m0_ack_o, 0);
    tick();
    tick();
    s_ack = 1; s_dat = 8'h77;
    #1;
    check("m0_ack", m0_ack_o, 1);
    check("m0_rdat", m0_dat_o, 8'h77);
    check("m1_no_ack", {m1_ack_o, m1_dat_o}, 0);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
    #1;
    check("m0_ack_1cyc", m0_ack_o, 0);
    tick();
    check("m0_release", grant, 0);
    reset_dut();
    m0_adr = 8'h11; m1_adr = 8'h22; m0_cyc = 1; m1_cyc = 1;
    tick();
    check("tie_grant", grant, 2'b01);
    check("tie_adr", s_adr_o, 8'h11);
    s_ack = 1;
    #1;
    check("tie_m1_noack", m1_ack_o, 0);
    check("tie_m0_ack", m0_ack_o, 1);
    s_ack = 0; m0_cyc = 0;
    tick();
    check("tie_idle_gap", grant, 0);
    tick();
    check("tie_m1_grant", grant, 2'b10);
    check("tie_m1_adr", s_adr_o, 8'h22);
    m1_cyc = 0;
    tick();
    m0_cyc = 1; m1_cyc = 1;
    #1;
    for (int i = 0; i < 8; i++) begin
      for (int w = 0; w < 4 && grant == 0; w++) tick();
      check($sformatf("alt_%0d", i), grant, (i % 2) ? 2'b10 : 2'b01);
      if (grant == 2'b01) m0_cyc = 0; else m1_cyc = 0;
      tick();
      check($sformatf("alt_gap_%0d", i), grant, 0);
      m0_cyc = 1; m1_cyc = 1;
      #1;
    end
    m0_cyc = 0; m1_cyc = 0;
    tick();
    tick();
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 8'h12;
    tick();
    check("wd_grant", grant, 2'b10);
    check("wd_stb", s_stb_o, 1);
    repeat (62) tick();
    check("wd_pre_exp", m1_ack_o, 0);
    tick();
    timeout_clr = 1;
    #1;
    check("wd_ack", m1_ack_o, 1);
    check("wd_dat", m1_dat_o, 8'hFF);
    check("wd_s_cs", {s_cyc_o, s_stb_o}, 0);
    check("wd_adr", s_adr_o, 8'h12);
    check("wd_m0_noack", m0_ack_o, 0);
    tick();
    timeout_clr = 0; m1_cyc = 0; m1_stb = 0;
    #1;
    check("wd_set_wins", timeout_flag, 1);
    check("wd_ack_1cyc", m1_ack_o, 0);
    tick();
    tick();
    check("wd_sticky", timeout_flag, 1);
    timeout_clr = 1;
    tick();
    timeout_clr = 0;
    check("wd_clr", timeout_flag, 0);
    m1_cyc = 1; m1_stb = 1;
    tick();
    repeat (63) tick();
    s_ack = 1; s_dat = 8'h3C;
    #1;
    check("race_ack", m1_ack_o, 1);
    check("race_dat", m1_dat_o, 8'h3C);
    check("race_stb", s_stb_o, 1);
    tick();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    #1;
    check("race_flag", timeout_flag, 0);
    tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = 8'h33; m1_cyc = 1;
    tick();
    check("mid_grant", grant, 2'b01);
    tick();
    rst_n = 0; s_ack = 1; m0_cyc = 0; m0_stb = 0;
    #1;
    check("mid_rst_grant", grant, 0);
    check("mid_rst_ack", m0_ack_o, 0);
    check("mid_rst_s", {s_cyc_o, s_stb_o, s_adr_o}, 0);
    check("mid_rst_dat", m0_dat_o, 0);
    s_ack = 0;
    tick();
    rst_n = 1;
    tick();
    check("post_rst_m1", grant, 2'b10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
